// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 8N1 UART transmitter between NUM_REQ byte sources.
// Optional build macro UART_ARB_FIXED_PRIO_EN selects fixed (lowest-index) priority instead.
module uart_tx_arbiter #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 115200,
    parameter int NUM_REQ   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   ack,
    output logic [7:0]           tx_data,
    output logic                 tx_send,
    output logic [2:0]           grant_id,
    output logic                 busy
);

    localparam int DIV          = CLK_FREQ / BAUD_RATE;
    localparam int FRAME_CYCLES = 10 * (DIV + 1);
    localparam int CNT_W        = $clog2(FRAME_CYCLES);
    localparam int IDX_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_send_q, tx_send_d;
    logic [2:0]           grant_id_q, grant_id_d;
    logic                 busy_q, busy_d;

    logic [2:0]           win;
    logic                 win_vld;

`ifdef UART_ARB_FIXED_PRIO_EN
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                win     = 3'(i);
                win_vld = 1'b1;
            end
        end
    end
`else
    // Walk from farthest to nearest so the first requester after grant_id overwrites last.
    always_comb begin
        logic [3:0] cand;
        cand    = '0;
        win     = grant_id_q;
        win_vld = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = {1'b0, grant_id_q} + 4'(k);
            if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
            if (req[cand[IDX_W-1:0]]) begin
                win     = cand[2:0];
                win_vld = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ack_d      = '0;
        tx_send_d  = 1'b0;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        busy_d     = busy_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d    = S_WAIT;
                    cnt_d      = CNT_LOAD;
                    tx_send_d  = 1'b1;
                    busy_d     = 1'b1;
                    grant_id_d = win;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (win == 3'(i)) begin
                            ack_d[i]  = 1'b1;
                            tx_data_d = req_data[8*i +: 8];
                        end
                    end
                end
            end
            S_WAIT: begin
                // The send cycle is the transmitter's load cycle; its frame count starts after it.
                if (tx_send_q) begin
                    cnt_d = cnt_q;
                end else if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ack_q      <= '0;
            tx_data_q  <= 8'h00;
            tx_send_q  <= 1'b0;
            grant_id_q <= 3'(NUM_REQ - 1);
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            tx_data_q  <= tx_data_d;
            tx_send_q  <= tx_send_d;
            grant_id_q <= grant_id_d;
            busy_q     <= busy_d;
        end
    end

    assign ack      = ack_q;
    assign tx_data  = tx_data_q;
    assign tx_send  = tx_send_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected grants queued at stimulus, popped at each send.
module tb_uart_tx_arbiter;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] req = '0;
    logic [8*NR-1:0] req_data = '0;
    logic [NR-1:0] ack;
    logic [7:0]    tx_data;
    logic          tx_send;
    logic [2:0]    grant_id;
    logic          busy;

    uart_tx_arbiter #(.CLK_FREQ(1000), .BAUD_RATE(100), .NUM_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
        .tx_data(tx_data), .tx_send(tx_send), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0] id;
        logic [7:0] data;
    } exp_t;
    exp_t sbq[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_send(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (tx_send === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        exp_t e;
        rst_n = 1'b0;
        req = 4'b1111;
        req_data = {8'h96, 8'h5A, 8'hC3, 8'h3C};
        repeat (3) @(negedge clk);
        tests++; if (ack !== 4'b0000) begin fails++; $display("FAIL reset_ack got %b exp 0000", ack); end
        tests++; if (tx_send !== 1'b0) begin fails++; $display("FAIL reset_tx_send got %b exp 0", tx_send); end
        tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL reset_tx_data got %h exp 00", tx_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests++; if (grant_id !== 3'd3) begin fails++; $display("FAIL reset_grant_id got %0d exp 3", grant_id); end
        sbq.push_back('{3'd0, 8'h3C});
        rst_n = 1'b1;
        wait_send(5, ok);
        tests++;
        if (!ok || sbq.size() == 0) begin
            fails++; $display("FAIL reset_first_send got none exp send within 5 cycles");
        end else begin
            e = sbq.pop_front();
            if (grant_id !== e.id || tx_data !== e.data || ack !== (4'b0001 << e.id)) begin
                fails++;
                $display("FAIL reset_first_grant got id=%0d data=%h ack=%b exp id=%0d data=%h", grant_id, tx_data, ack, e.id, e.data);
            end
        end
        req = 4'b0000;
        wait_idle(300, ok);
        tests++; if (!ok) begin fails++; $display("FAIL reset_idle got busy=1 exp busy=0 within 300"); end
    endtask

    task automatic test_single_byte();
        bit ok;
        int bc;
        exp_t e;
        req_data[8*2 +: 8] = 8'hA5;
        sbq.push_back('{3'd2, 8'hA5});
        req = 4'b0100;
        @(negedge clk);
        tests++;
        if (tx_send !== 1'b1 || sbq.size() == 0) begin
            fails++; $display("FAIL single_latency got tx_send=%b exp 1 after one cycle", tx_send);
        end else begin
            e = sbq.pop_front();
            if (grant_id !== e.id || tx_data !== e.data || ack !== (4'b0001 << e.id)) begin
                fails++;
                $display("FAIL single_grant got id=%0d data=%h ack=%b exp id=%0d data=%h", grant_id, tx_data, ack, e.id, e.data);
            end
        end
        req = 4'b0000;
        bc = 0;
        while (busy === 1'b1 && bc < 300) begin
            bc++;
            @(negedge clk);
        end
        tests++; if (bc != 111) begin fails++; $display("FAIL single_busy_len got %0d exp 111", bc); end
        tests++; if (tx_data !== 8'hA5) begin fails++; $display("FAIL single_tx_data_hold got %h exp a5", tx_data); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int prev;
        exp_t e;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_data = {8'h96, 8'h5A, 8'hC3, 8'h3C};
        sbq.push_back('{3'd0, 8'h3C});
        sbq.push_back('{3'd1, 8'hC3});
        sbq.push_back('{3'd2, 8'h5A});
        sbq.push_back('{3'd3, 8'h96});
        sbq.push_back('{3'd0, 8'h3C});
        req = 4'b1111;
        prev = 0;
        for (int n = 0; n < 5; n++) begin
            wait_send(300, ok);
            tests++;
            if (!ok || sbq.size() == 0) begin
                fails++; $display("FAIL rr_send%0d got none exp send within 300", n);
                break;
            end
            e = sbq.pop_front();
            if (grant_id !== e.id || tx_data !== e.data || ack !== (4'b0001 << e.id)) begin
                fails++;
                $display("FAIL rr_grant%0d got id=%0d data=%h ack=%b exp id=%0d data=%h", n, grant_id, tx_data, ack, e.id, e.data);
            end
            if (n > 0) begin
                tests++;
                if (cyc - prev != 112) begin fails++; $display("FAIL rr_spacing%0d got %0d exp 112", n, cyc - prev); end
            end
            prev = cyc;
            req[grant_id] = 1'b0;
            @(negedge clk);
            req = 4'b1111;
        end
        req = 4'b0000;
        wait_idle(300, ok);
        tests++; if (!ok) begin fails++; $display("FAIL rr_idle got busy=1 exp busy=0 within 300"); end
    endtask

    task automatic test_fixed_prio();
        bit ok;
        int prev;
        exp_t e;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_data[8*1 +: 8] = 8'hB1;
        req_data[8*3 +: 8] = 8'hD3;
        repeat (3) sbq.push_back('{3'd1, 8'hB1});
        req = 4'b1010;
        prev = 0;
        for (int n = 0; n < 3; n++) begin
            wait_send(300, ok);
            tests++;
            if (!ok || sbq.size() == 0) begin
                fails++; $display("FAIL fp_send%0d got none exp send within 300", n);
                break;
            end
            e = sbq.pop_front();
            if (grant_id !== e.id || tx_data !== e.data || ack !== (4'b0001 << e.id)) begin
                fails++;
                $display("FAIL fp_grant%0d got id=%0d data=%h ack=%b exp id=%0d data=%h", n, grant_id, tx_data, ack, e.id, e.data);
            end
            if (n > 0) begin
                tests++;
                if (cyc - prev != 112) begin fails++; $display("FAIL fp_spacing%0d got %0d exp 112", n, cyc - prev); end
            end
            prev = cyc;
        end
        req = 4'b0000;
        wait_idle(300, ok);
        tests++; if (!ok) begin fails++; $display("FAIL fp_idle got busy=1 exp busy=0 within 300"); end
    endtask

    task automatic test_withdraw();
        bit ok;
        int sends;
        int ack1;
        exp_t e;
        req_data[8*0 +: 8] = 8'h11;
        req_data[8*1 +: 8] = 8'h22;
        sbq.push_back('{3'd0, 8'h11});
        req = 4'b0001;
        wait_send(3, ok);
        tests++;
        if (!ok || sbq.size() == 0) begin
            fails++; $display("FAIL wd_send got none exp send within 3");
        end else begin
            e = sbq.pop_front();
            if (grant_id !== e.id || tx_data !== e.data || ack !== (4'b0001 << e.id)) begin
                fails++;
                $display("FAIL wd_grant got id=%0d data=%h ack=%b exp id=%0d data=%h", grant_id, tx_data, ack, e.id, e.data);
            end
        end
        req = 4'b0000;
        sends = 0;
        ack1 = 0;
        for (int i = 0; i < 150; i++) begin
            if (i == 20) req[1] = 1'b1;
            if (i == 25) req[1] = 1'b0;
            @(negedge clk);
            if (tx_send === 1'b1) sends++;
            if (ack[1] === 1'b1) ack1++;
        end
        tests++; if (sends != 0) begin fails++; $display("FAIL wd_extra_send got %0d exp 0", sends); end
        tests++; if (ack1 != 0) begin fails++; $display("FAIL wd_ack1 got %0d exp 0", ack1); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL wd_busy_end got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int sends;
        exp_t e;
        req_data[8*2 +: 8] = 8'h77;
        sbq.push_back('{3'd2, 8'h77});
        req = 4'b0100;
        wait_send(3, ok);
        tests++;
        if (!ok || sbq.size() == 0) begin
            fails++; $display("FAIL rm_send got none exp send within 3");
        end else begin
            e = sbq.pop_front();
            if (grant_id !== e.id || tx_data !== e.data) begin
                fails++; $display("FAIL rm_grant got id=%0d data=%h exp id=%0d data=%h", grant_id, tx_data, e.id, e.data);
            end
        end
        req = 4'b0000;
        repeat (40) @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rm_busy_before got %b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rm_busy_drop got %b exp 0", busy); end
        sends = 0;
        repeat (3) begin
            @(negedge clk);
            if (tx_send === 1'b1) sends++;
        end
        tests++; if (sends != 0) begin fails++; $display("FAIL rm_send_in_reset got %0d exp 0", sends); end
        rst_n = 1'b1;
        @(negedge clk);
        req_data[8*3 +: 8] = 8'hE1;
        sbq.push_back('{3'd3, 8'hE1});
        req = 4'b1000;
        @(negedge clk);
        tests++;
        if (tx_send !== 1'b1 || sbq.size() == 0) begin
            fails++; $display("FAIL rm_latency got tx_send=%b exp 1 after one cycle", tx_send);
        end else begin
            e = sbq.pop_front();
            if (grant_id !== e.id || tx_data !== e.data || ack !== (4'b0001 << e.id)) begin
                fails++;
                $display("FAIL rm_grant_after got id=%0d data=%h ack=%b exp id=%0d data=%h", grant_id, tx_data, ack, e.id, e.data);
            end
        end
        req = 4'b0000;
        wait_idle(300, ok);
        tests++; if (!ok) begin fails++; $display("FAIL rm_idle got busy=1 exp busy=0 within 300"); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
`ifdef UART_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_round_robin();
`endif
        test_withdraw();
        test_reset_mid_frame();
        tests++;
        if (sbq.size() != 0) begin fails++; $display("FAIL scoreboard_drain got %0d left exp 0", sbq.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one 8N1 UART transmitter between `NUM_REQ` byte-producing requesters. Each byte is granted by round-robin arbitration and driven into the transmitter's `data`/`send` inputs with a one-cycle `send` pulse. The transmitter has no busy output, so the arbiter counts the frame time itself and issues no new `send` until the frame has finished. It sits between the system's message sources (status, debug, command echo) and the UART transmitter, in the same clock domain.

## Interface
- `CLK_FREQ`, default 50000000: system clock in Hz; must match the transmitter.
- `BAUD_RATE`, default 115200: line rate; must match the transmitter.
- `NUM_REQ`, default 4: number of requesters, 2..8.
- Derived: `DIV = CLK_FREQ/BAUD_RATE` (integer divide); `FRAME_CYCLES = 10*(DIV+1)`; counter width `$clog2(FRAME_CYCLES)`.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  NUM_REQ  per-requester byte request. Level-sensitive; held until the matching `ack`.
- `req_data`  in  8*NUM_REQ  flattened bytes; requester i uses bits [8i+7:8i]. Stable while `req[i]` is high.
- `ack`  out  NUM_REQ  one-cycle pulse: the byte of requester i has been accepted.
- `tx_data`  out  8  byte to the transmitter `data` input (registered).
- `tx_send`  out  1  one-cycle pulse to the transmitter `send` input.
- `grant_id`  out  3  index of the last granted requester.
- `busy`  out  1  high from the `tx_send` cycle until the arbiter is back in IDLE.

## Operation
- States:
  - IDLE: no frame in flight.
  - WAIT: frame in flight; the down-counter `cnt` is running.
- IDLE with `req == 0`: stay in IDLE; all outputs hold their idle values.
- IDLE with any `req` bit high, at the clock edge:
  - select winner w;
  - `tx_data <= req_data[w]`, `ack[w] <= 1`, `tx_send <= 1`, `grant_id <= w`, `busy <= 1`;
  - `cnt <= FRAME_CYCLES-1`; state <= WAIT.
- WAIT:
  - `ack` and `tx_send` return to 0 after one cycle.
  - `cnt` decrements by 1 per cycle.
  - At `cnt == 0`: state <= IDLE and `busy <= 0`.
  - All `req` activity is ignored.
- Round-robin selection: search starts at `grant_id+1` and wraps modulo `NUM_REQ`. The first asserted `req` bit wins.
- Requester handshake:
  - `req[i]` must drop in the cycle after it sees `ack[i]`, or it is treated as a new byte at the next IDLE.
  - Dropping `req` before `ack` withdraws the byte; no `ack` and no `send` are issued for it.
- `tx_data` holds its value between grants.

## Timing
- Reset (async assert, sync-safe deassert), all outputs and state:
  - `ack = 0`, `tx_send = 0`, `tx_data = 8'h00`, `busy = 0`;
  - `grant_id = NUM_REQ-1`, so requester 0 wins first;
  - `cnt = 0`, state IDLE.
- Request-to-send latency: `req` high in an IDLE cycle → `ack` and `tx_send` high in the next cycle.
- Send-to-send spacing under continuous requests: exactly `FRAME_CYCLES+2` cycles. This gives one cycle of margin beyond the transmitter's busy window of `10*(DIV+1)` cycles after its load cycle.
- `busy` high for exactly `FRAME_CYCLES+1` cycles per frame.
- Simultaneous requests: exactly one `ack` per frame; the others wait in order of round-robin priority.
- Reset mid-frame: the arbiter returns to IDLE at once and no `send` is issued. The transmitter is reset from the same source; any partial frame is abandoned.
- `DIV` must be ≥ 1; the counter never wraps because it is loaded only from IDLE.

## Configuration
- `UART_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority. The lowest asserted index always wins and `grant_id` is not used for selection; it still reports the last winner.
  - Undefined (default): round-robin as described above.

## Test plan
All scenarios use `CLK_FREQ=1000`, `BAUD_RATE=100`, `NUM_REQ=4`, giving `DIV=10`, `FRAME_CYCLES=110`.

- Reset: `rst_n` low for 3 cycles with `req=4'b1111` → `ack=0`, `tx_send=0`, `tx_data=8'h00`, `busy=0`, `grant_id=3`; first grant after release is to requester 0.
- Single byte: `req[2]=1`, byte 8'hA5 → next cycle `ack=4'b0100`, `tx_send=1`, `tx_data=8'hA5`; `busy` high for 111 cycles; transmitter serialises 0,1,0,1,0,0,1,0,1,1 on `tx`.
- Round-robin fairness: `req=4'b1111` held, each bit re-asserted after its ack → grant order 0,1,2,3,0; `tx_send` pulses exactly 112 cycles apart; decoded bytes match the per-requester data.
- Withdrawal and ignore: `req[1]` pulsed during WAIT, then dropped before IDLE → no `ack[1]` and no extra `tx_send`.
- Reset mid-frame: `rst_n` low 40 cycles after `tx_send` → `busy` falls immediately; after release, a new `req[3]` gets `ack` in 1 cycle.
- Fixed priority (`UART_ARB_FIXED_PRIO_EN` defined): `req=4'b1010` held continuously → requester 1 wins every frame; requester 3 is starved.
